// File: rtl/alu_arb_rr.sv
// alu_arb_rr: registered round-robin arbiter sharing GNTS_N ALUs among PORTS_N clients
// Optional feature macro ALU_ARB_RELEASE_GAP_EN: a released ALU drains for one extra cycle before reuse
module alu_arb_rr #(
   parameter int PORTS_N = 2,
   parameter int GNTS_N  = 2,
   parameter int GNTS_W  = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [PORTS_N-1:0]        req,
   input  logic [GNTS_N-1:0]         res_en,
   output logic [PORTS_N-1:0]        gnt,
   output logic [PORTS_N*GNTS_W-1:0] gnt_id,
   output logic [GNTS_N-1:0]         res_busy
);
   localparam int PW = (PORTS_N > 1) ? $clog2(PORTS_N) : 1;
   logic [PW-1:0]             rr_ptr, rr_ptr_n, p;
   logic [PW:0]               sum;
   logic [PORTS_N-1:0]        gnt_n;
   logic [PORTS_N*GNTS_W-1:0] gnt_id_n;
   logic [GNTS_N-1:0]         own, free, avail, busy_n;
   logic                      taken;
`ifdef ALU_ARB_RELEASE_GAP_EN
   logic [GNTS_N-1:0]         rel, drain;
`endif

   // decode which ALUs are owned right now and which become free for this edge
   always_comb begin
      own = '0;
`ifdef ALU_ARB_RELEASE_GAP_EN
      rel = '0;
`endif
      for (int j = 0; j < PORTS_N; j++)
         for (int k = 0; k < GNTS_N; k++)
            if (gnt[j] && gnt_id[GNTS_W*j +: GNTS_W] == GNTS_W'(k)) begin
               own[k] = 1'b1;
`ifdef ALU_ARB_RELEASE_GAP_EN
               if (!req[j]) rel[k] = 1'b1;
`endif
            end
`ifdef ALU_ARB_RELEASE_GAP_EN
      free = ~own & ~drain & res_en;
`else
      free = ~own & res_en;
`endif
   end

   // drop released grants, then hand free ALUs (ascending) to pending ports in round-robin order
   always_comb begin
      gnt_n    = gnt;
      gnt_id_n = gnt_id;
      rr_ptr_n = rr_ptr;
      avail    = free;
      sum      = '0;
      p        = '0;
      taken    = 1'b0;
      busy_n   = '0;
      for (int j = 0; j < PORTS_N; j++)
         if (gnt[j] && !req[j]) begin
            gnt_n[j] = 1'b0;
            gnt_id_n[GNTS_W*j +: GNTS_W] = '0;
         end
      for (int i = 0; i < PORTS_N; i++) begin
         sum = {1'b0, rr_ptr} + (PW+1)'(i);
         p   = (sum >= (PW+1)'(PORTS_N)) ? PW'(sum - (PW+1)'(PORTS_N)) : PW'(sum);
         for (int j = 0; j < PORTS_N; j++)
            if (p == PW'(j) && req[j] && !gnt[j]) begin
               taken = 1'b0;
               for (int k = 0; k < GNTS_N; k++)
                  if (!taken && avail[k]) begin
                     taken    = 1'b1;
                     avail[k] = 1'b0;
                     gnt_n[j] = 1'b1;
                     gnt_id_n[GNTS_W*j +: GNTS_W] = GNTS_W'(k);
                     rr_ptr_n = (j == PORTS_N-1) ? '0 : PW'(j+1);
                  end
            end
      end
      for (int j = 0; j < PORTS_N; j++)
         for (int k = 0; k < GNTS_N; k++)
            if (gnt_n[j] && gnt_id_n[GNTS_W*j +: GNTS_W] == GNTS_W'(k)) busy_n[k] = 1'b1;
`ifdef ALU_ARB_RELEASE_GAP_EN
      busy_n = busy_n | rel;
`endif
   end

   // grant, index, occupancy and pointer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt      <= '0;
         gnt_id   <= '0;
         res_busy <= '0;
         rr_ptr   <= '0;
`ifdef ALU_ARB_RELEASE_GAP_EN
         drain    <= '0;
`endif
      end else begin
         gnt      <= gnt_n;
         gnt_id   <= gnt_id_n;
         res_busy <= busy_n;
         rr_ptr   <= rr_ptr_n;
`ifdef ALU_ARB_RELEASE_GAP_EN
         drain    <= rel;
`endif
      end
   end
endmodule

// File: tb/tb_alu_arb_rr.sv
// tb_alu_arb_rr: vector table, rotation sequence, random run against an owner-list model, drain-gap check
module tb_alu_arb_rr;
   logic       clk = 1'b0, reset = 1'b1;
   logic [3:0] req = '0, gnt, gnt_id;
   logic [1:0] res_en = 2'b11, res_busy;
   logic [1:0] req2 = '0, gnt2, id2;
   logic [0:0] en2 = 1'b1, busy2;
   int total = 0, bad = 0;
   int m_port_res[4], m_res_owner[2], m_rr, m_rel;

   typedef struct {
      logic rst; logic [3:0] rq; logic [1:0] en;
      logic [3:0] eg; logic [3:0] ei; logic [1:0] eb;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   alu_arb_rr #(.PORTS_N(4), .GNTS_N(2), .GNTS_W(1)) dut (
      .clk(clk), .reset(reset), .req(req), .res_en(res_en),
      .gnt(gnt), .gnt_id(gnt_id), .res_busy(res_busy));

   alu_arb_rr #(.PORTS_N(2), .GNTS_N(1), .GNTS_W(1)) dut1 (
      .clk(clk), .reset(reset), .req(req2), .res_en(en2),
      .gnt(gnt2), .gnt_id(id2), .res_busy(busy2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // owner-list model: free list taken before releases, pending ports scanned from the pointer
   function automatic void model_step();
      int fr[$];
      int last = 0, p, k;
      bit any = 0;
      m_rel = 0;
      if (reset) begin
         foreach (m_port_res[j]) m_port_res[j] = -1;
         foreach (m_res_owner[r]) m_res_owner[r] = -1;
         m_rr = 0;
         return;
      end
      for (int r = 0; r < 2; r++) if (m_res_owner[r] < 0 && res_en[r]) fr.push_back(r);
      for (int j = 0; j < 4; j++)
         if (m_port_res[j] >= 0 && !req[j]) begin
            m_res_owner[m_port_res[j]] = -1;
            m_port_res[j] = -1;
            m_rel++;
         end
      for (int i = 0; i < 4; i++) begin
         p = (m_rr + i) % 4;
         if (req[p] && m_port_res[p] < 0 && fr.size() > 0) begin
            k = fr.pop_front();
            m_port_res[p] = k;
            m_res_owner[k] = p;
            last = p;
            any = 1;
         end
      end
      if (any) m_rr = (last + 1) % 4;
   endfunction

   task automatic cmp_model(input string tag);
      logic [3:0] eg = '0, ei = '0;
      logic [1:0] eb = '0;
      for (int j = 0; j < 4; j++)
         if (m_port_res[j] >= 0) begin
            eg[j] = 1'b1;
            ei[j] = (m_port_res[j] == 1);
         end
      for (int r = 0; r < 2; r++) eb[r] = (m_res_owner[r] >= 0);
      chk({tag, "_gnt"}, gnt, eg);
      chk({tag, "_id"}, gnt_id, ei);
      chk({tag, "_busy"}, res_busy, eb);
   endtask

   task automatic inv();
      int dup = 0;
      logic [1:0] b = '0;
      for (int i = 0; i < 4; i++) begin
         if (gnt[i]) b[gnt_id[i]] = 1'b1;
         for (int j = i + 1; j < 4; j++)
            if (gnt[i] && gnt[j] && gnt_id[i] == gnt_id[j]) dup = 1;
      end
      chk("inv_unique", dup, 0);
      chk("inv_count", $countones(gnt), $countones(res_busy));
      chk("inv_busy", res_busy, b);
   endtask

   task automatic step(input logic r_rst, input logic [3:0] r_req, input logic [1:0] r_en);
      reset = r_rst;
      req = r_req;
      res_en = r_en;
      @(posedge clk);
      model_step();
      #1;
   endtask

   function automatic void add(input logic r, input logic [3:0] q, input logic [1:0] e,
                               input logic [3:0] g, input logic [3:0] i, input logic [1:0] b);
      vec_t v;
      v.rst = r; v.rq = q; v.en = e; v.eg = g; v.ei = i; v.eb = b;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [3:0] reqv, pend;
      int h[4], w[4], ord[$], exp_ord[6];
      int wmax = 0, relc;
      add(1, 4'b0000, 2'b11, 4'b0000, 4'b0000, 2'b00);
      add(1, 4'b0000, 2'b11, 4'b0000, 4'b0000, 2'b00);
      add(1, 4'b0000, 2'b11, 4'b0000, 4'b0000, 2'b00);
      add(0, 4'b0001, 2'b11, 4'b0001, 4'b0000, 2'b01);
      add(1, 4'b0000, 2'b11, 4'b0000, 4'b0000, 2'b00);
      add(0, 4'b1111, 2'b11, 4'b0011, 4'b0010, 2'b11);
      add(0, 4'b1110, 2'b11, 4'b0010, 4'b0010, 2'b10);
      add(0, 4'b1110, 2'b11, 4'b0110, 4'b0010, 2'b11);
      add(1, 4'b1111, 2'b11, 4'b0000, 4'b0000, 2'b00);
      add(0, 4'b0011, 2'b11, 4'b0011, 4'b0010, 2'b11);
      add(1, 4'b0011, 2'b11, 4'b0000, 4'b0000, 2'b00);
      add(0, 4'b1111, 2'b11, 4'b0011, 4'b0010, 2'b11);
      add(1, 4'b0000, 2'b11, 4'b0000, 4'b0000, 2'b00);
      add(0, 4'b0011, 2'b10, 4'b0001, 4'b0001, 2'b10);
      add(0, 4'b0011, 2'b00, 4'b0001, 4'b0001, 2'b10);
      add(0, 4'b0001, 2'b00, 4'b0001, 4'b0001, 2'b10);
      add(0, 4'b0011, 2'b00, 4'b0001, 4'b0001, 2'b10);
      add(0, 4'b0010, 2'b00, 4'b0000, 4'b0000, 2'b00);
      add(0, 4'b0010, 2'b00, 4'b0000, 4'b0000, 2'b00);
      add(0, 4'b0010, 2'b01, 4'b0010, 4'b0000, 2'b01);
      add(0, 4'b0000, 2'b01, 4'b0000, 4'b0000, 2'b00);
      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].rq, tbl[i].en);
         chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].eg);
         chk($sformatf("vec%0d_id", i), gnt_id, tbl[i].ei);
         chk($sformatf("vec%0d_busy", i), res_busy, tbl[i].eb);
         inv();
      end
      // continuous contention: hold three cycles, drop one, re-request
      step(1, 4'b0000, 2'b11);
      reqv = 4'b1111;
      foreach (h[j]) begin h[j] = 0; w[j] = 0; end
      for (int c = 0; c < 32; c++) begin
         pend = reqv & ~gnt;
         relc = $countones(gnt & ~reqv);
         reqv = reqv;
         begin
            logic [3:0] prev;
            prev = gnt;
            step(0, reqv, 2'b11);
            for (int j = 0; j < 4; j++) if (gnt[j] && !prev[j]) ord.push_back(j);
         end
         cmp_model("rot");
         inv();
         for (int j = 0; j < 4; j++) begin
            if (pend[j]) begin
               if (gnt[j]) w[j] = 0;
               else begin
                  w[j] += relc;
                  if (w[j] > wmax) wmax = w[j];
               end
            end
            if (!reqv[j]) reqv[j] = 1'b1;
            else if (gnt[j]) begin
               h[j]++;
               if (h[j] == 3) begin
                  reqv[j] = 1'b0;
                  h[j] = 0;
               end
            end
         end
      end
      exp_ord = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) chk($sformatf("order%0d", i), (ord.size() > i) ? ord[i] : -1, exp_ord[i]);
      chk("max_wait_le2", wmax <= 2, 1);
      // random traffic against the model
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 49) == 0, 4'($urandom),
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11);
         cmp_model("rnd");
         inv();
      end
      // release gap on a single-ALU instance
      step(1, 4'b0000, 2'b11);
      req2 = 2'b11;
      step(0, 4'b0000, 2'b11);
      chk("gap_a_gnt", gnt2, 2'b01);
      chk("gap_a_busy", busy2, 1'b1);
      req2 = 2'b10;
      step(0, 4'b0000, 2'b11);
      chk("gap_e_gnt", gnt2, 2'b00);
`ifdef ALU_ARB_RELEASE_GAP_EN
      chk("gap_e_busy", busy2, 1'b1);
      step(0, 4'b0000, 2'b11);
      chk("gap_e1_gnt", gnt2, 2'b00);
`else
      chk("gap_e_busy", busy2, 1'b0);
      step(0, 4'b0000, 2'b11);
      chk("gap_e1_gnt", gnt2, 2'b10);
`endif
      step(0, 4'b0000, 2'b11);
      chk("gap_e2_gnt", gnt2, 2'b10);
      chk("gap_e2_id", id2, 2'b00);
      chk("gap_e2_busy", busy2, 1'b1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_arb_rr.md
Name: alu_arb_rr

Overview:
- Registered round-robin arbiter that shares GNTS_N DSP ALU instances between PORTS_N requesting clients.
- A granted client keeps its ALU for as long as its request (bus cycle) stays high.
- Outputs are a per-port grant bit and a per-port resource index, which drive the client/ALU interconnect mux.
- Also reports per-resource occupancy and honours a per-resource enable so that an ALU can be drained and taken out of service.

Parameters:
- PORTS_N, 2: number of requesting clients.
- GNTS_N, 2: number of shareable ALU resources. Must satisfy GNTS_N <= 2**GNTS_W.
- GNTS_W, 1: width of one resource index.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  PORTS_N  per-client request; equals that client's bus cycle signal.
- res_en  input  GNTS_N  resource may receive new grants when 1.
- gnt  output  PORTS_N  registered; client j currently owns a resource.
- gnt_id  output  PORTS_N*GNTS_W  registered; index of the resource owned by client j, in slice [GNTS_W*j +: GNTS_W].
- res_busy  output  GNTS_N  registered; resource k is currently owned by some client.

Behaviour:
- Reset: gnt=0, gnt_id=0, res_busy=0, rr_ptr=0.
  - Reset asserted mid-operation drops every grant and frees every resource at that edge, regardless of req.
- Per-port state machine:
  - IDLE -> GRANTED when the port is selected at an edge.
  - GRANTED -> IDLE at the first edge where req[j]=0 is sampled.
  - GRANTED holds otherwise.
  - gnt[j]=1 exactly in GRANTED.
  - gnt_id slice is valid in GRANTED and forced to 0 in IDLE.
- Latency:
  - req rising before edge E with a free resource gives gnt=1 after edge E (1 cycle).
  - req falling before edge E gives gnt=0 after edge E.
  - The released resource is assignable at edge E+1 at the earliest, never at the same edge it is freed.
- A resource is free when it is not owned, not released at the current edge, and res_en[k]=1.
- Grants are never revoked: clearing res_en[k] does not disturb its current owner. res_busy[k] stays 1 until that owner drops req.
- Allocation at each edge:
  - Pending set = ports with req=1 in IDLE.
  - Scan pending ports in round-robin order starting at rr_ptr, wrapping PORTS_N-1 -> 0.
  - Scan free resources in ascending index order.
  - The i-th selected port gets the i-th free resource.
  - Grants issued per edge = min(pending, free); several grants in one edge are allowed.
- rr_ptr:
  - Advances to (last port granted this edge + 1) mod PORTS_N when at least one grant is issued.
  - Unchanged otherwise.
- Pending ports with no free resource stay IDLE and do not count as granted. This guarantees that no requester waits more than ceil(PORTS_N/GNTS_N) release events under continuous contention.
- Invariants (checked by assertion in the bench):
  - No two granted ports share a gnt_id.
  - popcount(gnt) == popcount(res_busy).
  - res_busy[k] = OR over j of (gnt[j] & gnt_id_j==k).
- req toggling while IDLE with no free resource has no effect; nothing is queued or latched.

Optional Feature:
- Macro: ALU_ARB_RELEASE_GAP_EN.
- Defined: a resource released at edge E enters a one-cycle DRAIN state.
  - res_busy stays 1 through E+1.
  - It is first assignable at edge E+2, giving the ALU pipeline time to retire the last result.
- Undefined: no DRAIN state; first assignable at E+1 as above.

Test Plan:
- PORTS_N=4, GNTS_N=2, GNTS_W=1, res_en=11. reset 3 cycles, then req=0001 -> one cycle later gnt=0001, gnt_id[0]=0, res_busy=01, rr_ptr=1.
- From idle with rr_ptr=0, req=1111 in one cycle -> next cycle gnt=0011, port0 id 0, port1 id 1, res_busy=11, rr_ptr=2.
  - Then drop req[0] -> next cycle gnt=0010, res_busy=10.
  - Following cycle gnt=0110, port2 id 0.
- Continuous req=1111, each owner holds for 3 cycles then drops for 1 cycle -> grant order 0,1,2,3,0,1...
  - Resource indices never collide.
  - Max wait per port is at most 2 release events.
- res_en=10 with req=0011 -> only port0 granted, id 1.
  - Clear res_en to 00 while port0 holds -> gnt unchanged.
  - Port0 drops req -> port1 stays ungranted until res_en returns nonzero.
- Grants 0011 held, assert reset one cycle -> next cycle gnt=0000, gnt_id=0, res_busy=00, rr_ptr=0.
  - Release reset with req=1111 -> regrants as in scenario 2.
- With ALU_ARB_RELEASE_GAP_EN defined, GNTS_N=1, req=0011 -> port0 granted.
  - Drop req[0] at edge E -> res_busy high through E+1.
  - Port1 granted at E+2, not E+1.
  - Undefined build grants port1 at E+1.
